// File: rtl/execute_mdu.sv
// execute_mdu: execute-stage operand forwarding with a configurable
// writeback history, plus an iterative RV32M multiply/divide unit.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rs1, rs2                    register-file operands
//   writeback                   current WB-stage value (forwarding source 1)
//   a_forward_select            0 = rs1, k = forwarding source k
//   b_forward_select            0 = rs2, k = forwarding source k
//   fwd_rs1, fwd_rs2            forwarded operands (combinational)
//   md_valid, md_funct3         M-extension request and its funct3
//   flush                       kill the in-flight or requested MDU op
//   md_ready                    MDU idle, can accept
//   md_done, md_result          one-cycle completion pulse and result
//   stall                       hold IF/ID/EX while the MDU is busy
//
// Handshake: an op is accepted on a cycle where md_valid & md_ready & !flush.
// The requester keeps md_valid high until the cycle md_done is seen; stall is
// md_valid & !md_done, so the pipeline advances exactly on the done cycle.
//
// FWD_DEPTH must be at least 2 (history holds sources 2..FWD_DEPTH).
module execute_mdu #(
    parameter int XLEN      = 32,
    parameter int FWD_DEPTH = 2,
    parameter int SELW      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] writeback,
    input  logic [SELW-1:0] a_forward_select,
    input  logic [SELW-1:0] b_forward_select,
    output logic [XLEN-1:0] fwd_rs1,
    output logic [XLEN-1:0] fwd_rs2,
    input  logic            md_valid,
    input  logic [2:0]      md_funct3,
    input  logic            flush,
    output logic            md_ready,
    output logic            md_done,
    output logic [XLEN-1:0] md_result,
    output logic            stall
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits shifting out / quotient shifting in}
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]       opd_q, opd_d;       // multiplicand or divisor magnitude
    logic [2:0]            funct3_q, funct3_d;
    logic                  neg_q, neg_d;       // negate product / quotient
    logic                  rneg_q, rneg_d;     // negate remainder
    logic [XLEN-1:0]       result_q, result_d;
    logic [XLEN-1:0]       hist_q [FWD_DEPTH:2];

    // ---------------------------------------------------------------
    // Forwarding
    // ---------------------------------------------------------------
    always_comb begin
        fwd_rs1 = rs1;
        if (a_forward_select == SELW'(1)) fwd_rs1 = writeback;
        for (int k = 2; k <= FWD_DEPTH; k++) begin
            if (a_forward_select == SELW'(k)) fwd_rs1 = hist_q[k];
        end
    end

    always_comb begin
        fwd_rs2 = rs2;
        if (b_forward_select == SELW'(1)) fwd_rs2 = writeback;
        for (int k = 2; k <= FWD_DEPTH; k++) begin
            if (b_forward_select == SELW'(k)) fwd_rs2 = hist_q[k];
        end
    end

    // History only moves when the pipeline moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 2; k <= FWD_DEPTH; k++) hist_q[k] <= '0;
        end else if (!stall) begin
            hist_q[2] <= writeback;
            for (int k = 3; k <= FWD_DEPTH; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    // ---------------------------------------------------------------
    // Handshake outputs
    // ---------------------------------------------------------------
    logic accept;

    assign md_ready  = (state_q == S_IDLE);
    assign accept    = md_valid & md_ready & ~flush;
    assign md_done   = (state_q == S_DONE) & ~flush;
    assign md_result = result_q;
    assign stall     = md_valid & ~md_done;

    // ---------------------------------------------------------------
    // Operand preparation at accept
    // ---------------------------------------------------------------
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        is_div = md_funct3[2];
        // DIV/REM are signed (funct3 bit0 clear); MULH both, MULHSU rs1 only.
        a_sgn  = is_div ? ~md_funct3[0] : (md_funct3 == 3'd1 || md_funct3 == 3'd2);
        b_sgn  = is_div ? ~md_funct3[0] : (md_funct3 == 3'd1);
        a_neg  = a_sgn & fwd_rs1[XLEN-1];
        b_neg  = b_sgn & fwd_rs2[XLEN-1];
        a_mag  = a_neg ? -fwd_rs1 : fwd_rs1;
        b_mag  = b_neg ? -fwd_rs2 : fwd_rs2;

        div_zero = is_div & (fwd_rs2 == '0);
        div_ovf  = is_div & ~md_funct3[0]
                 & (fwd_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                 & (fwd_rs2 == '1);

        // funct3 bit1 selects remainder (REM/REMU) over quotient (DIV/DIVU).
        if (md_funct3[1]) special_res = div_zero ? fwd_rs1 : '0;
        else              special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // ---------------------------------------------------------------
    // One iteration of each algorithm, and the final result fix-up
    // ---------------------------------------------------------------
    logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   mul_res, div_quo, div_rem, div_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opd_q : '0)};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opd_q};
        if (!div_diff[XLEN+1]) div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                   div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        prod_fix = neg_q ? -mul_next : mul_next;
        mul_res  = (funct3_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

        div_quo  = div_next[XLEN-1:0];
        div_rem  = div_next[2*XLEN-1:XLEN];
        div_res  = funct3_q[1] ? (rneg_q ? -div_rem : div_rem)
                               : (neg_q  ? -div_quo : div_quo);
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    funct3_d = md_funct3;
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    cnt_d    = '0;
                    if (is_div) begin
                        opd_d = b_mag;
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_DIV;
                        end
                    end else begin
                        opd_d   = a_mag;
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    result_d = mul_res;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_execute_mdu.sv
// Testbench for execute_mdu (XLEN=32, FWD_DEPTH=3, SELW=2).
module tb_execute_mdu;

    localparam int XLEN = 32;
    localparam int FWD_DEPTH = 3;
    localparam int SELW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [XLEN-1:0] rs1 = '0, rs2 = '0, writeback = '0;
    logic [SELW-1:0] a_forward_select = '0, b_forward_select = '0;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2, md_result;
    logic            md_valid = 1'b0, flush = 1'b0;
    logic [2:0]      md_funct3 = '0;
    logic            md_ready, md_done, stall;

    execute_mdu #(.XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1(rs1), .rs2(rs2), .writeback(writeback),
        .a_forward_select(a_forward_select), .b_forward_select(b_forward_select),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .md_valid(md_valid), .md_funct3(md_funct3), .flush(flush),
        .md_ready(md_ready), .md_done(md_done), .md_result(md_result),
        .stall(stall)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; that cycle is the accept cycle (cycle 0).
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit via_wb,
                          input logic [31:0] exp_r, input int exp_lat);
        int done_cyc = -1;
        int stall_bad = 0;
        logic [31:0] got;
        md_funct3 = f;
        rs2 = b;
        b_forward_select = '0;
        if (via_wb) begin
            writeback = a;
            rs1 = ~a;
            a_forward_select = SELW'(1);
        end else begin
            rs1 = a;
            a_forward_select = '0;
        end
        md_valid = 1'b1;
        exp_q.push_back(exp_r);
        for (int c = 0; c < XLEN + 8 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 0) check({name, " ready@accept"}, 32'(md_ready), 32'd1);
            if (c == 1) check({name, " busy@1"}, 32'(md_ready), 32'd0);
            if (md_done) begin
                done_cyc = c;
                got = md_result;
                check({name, " stall@done"}, 32'(stall), 32'd0);
                check({name, " result"}, got, exp_q.pop_front());
            end else if (!stall) begin
                stall_bad++;
            end
            @(posedge clk); #1;
            if (c == 0) begin
                // The op must ignore operand changes after accept.
                rs1 = $urandom;
                rs2 = $urandom;
                writeback = $urandom;
            end
        end
        if (done_cyc < 0) begin
            void'(exp_q.pop_front());
            flush = 1'b1;
            md_valid = 1'b0;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        md_valid = 1'b0;
        check({name, " latency"}, 32'(done_cyc), 32'(exp_lat));
        check({name, " stall_gaps"}, 32'(stall_bad), 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_fa[4];
        logic [31:0] exp_fb[4];
        int seen;

        tbl[0]  = '{"MUL",      3'd0, 32'hFFFF_FFFF, 32'h2,          32'hFFFF_FFFE, 33};
        tbl[1]  = '{"MULHU",    3'd3, 32'hFFFF_FFFF, 32'h2,          32'h0000_0001, 33};
        tbl[2]  = '{"MULH",     3'd1, 32'hFFFF_FFFF, 32'h2,          32'hFFFF_FFFF, 33};
        tbl[3]  = '{"MULHSU",   3'd2, 32'h2,         32'hFFFF_FFFF,  32'h0000_0001, 33};
        tbl[4]  = '{"DIV-7/2",  3'd4, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD, 33};
        tbl[5]  = '{"REM-7/2",  3'd6, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 33};
        tbl[6]  = '{"DIVU",     3'd5, 32'd100,       32'd7,          32'd14,        33};
        tbl[7]  = '{"REMU",     3'd7, 32'd100,       32'd7,          32'd2,         33};
        tbl[8]  = '{"DIV/0",    3'd4, 32'd5,         32'd0,          32'hFFFF_FFFF, 1};
        tbl[9]  = '{"REM/0",    3'd6, 32'd5,         32'd0,          32'd5,         1};
        tbl[10] = '{"DIVovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1};
        tbl[11] = '{"REMovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         1};
        tbl[12] = '{"DIVUbig",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         33};
        tbl[13] = '{"REMU/0",   3'd7, 32'd7,         32'd0,          32'd7,         1};
        tbl[14] = '{"MULneg",   3'd0, 32'd7,         32'hFFFF_FFFD,  32'hFFFF_FFEB, 33};
        tbl[15] = '{"REM7/-2",  3'd6, 32'd7,         32'hFFFF_FFFE,  32'd1,         33};

        // ---- reset state ----
        rs1 = 32'h1234_5678;
        a_forward_select = SELW'(2);
        @(negedge clk);
        check("rst md_ready", 32'(md_ready), 32'd1);
        check("rst stall", 32'(stall), 32'd0);
        check("rst md_done", 32'(md_done), 32'd0);
        check("rst md_result", md_result, 32'd0);
        check("rst hist2", fwd_rs1, 32'd0);
        #7 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- forwarding history ----
        a_forward_select = '0;
        writeback = 32'h11; @(posedge clk); #1;
        writeback = 32'h22; @(posedge clk); #1;
        writeback = 32'h33;
        rs1 = 32'hAAAA; rs2 = 32'hBBBB;
        exp_fa = '{32'hAAAA, 32'h33, 32'h22, 32'h11};
        exp_fb = '{32'hBBBB, 32'h33, 32'h22, 32'h11};
        for (int s = 0; s < 4; s++) begin
            a_forward_select = SELW'(s);
            b_forward_select = SELW'(3 - s);
            #1;
            check($sformatf("fwd_a sel%0d", s), fwd_rs1, exp_fa[s]);
            check($sformatf("fwd_b sel%0d", 3 - s), fwd_rs2, exp_fb[3 - s]);
        end
        @(posedge clk); #1;

        // ---- directed table ----
        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].name, tbl[i].f, tbl[i].a, tbl[i].b, 1'b0, tbl[i].r, tbl[i].lat);
        end

        // ---- randomized ops against the model ----
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            int mode;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) b = 32'($urandom_range(1, 20));
            run_op($sformatf("rnd%0d f%0d", i, f), f, a, b, 1'($urandom_range(0, 1)),
                   model(f, a, b), model_lat(f, a, b));
        end

        // ---- flush at cycle 10 of a MUL ----
        rs1 = 32'd3; rs2 = 32'd5; md_funct3 = 3'd0;
        a_forward_select = '0; b_forward_select = '0;
        md_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (md_done) seen++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        if (md_done) seen++;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush no_done", 32'(seen), 32'd0);
        run_op("DIVU9/3 after flush", 3'd5, 32'd9, 32'd3, 1'b0, 32'd3, 33);

        // ---- flush during DONE ----
        rs1 = 32'd5; rs2 = 32'd0; md_funct3 = 3'd4; md_valid = 1'b1;
        @(posedge clk); #1;
        md_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush@done md_done", 32'(md_done), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush@done ready", 32'(md_ready), 32'd1);
        @(posedge clk); #1;

        // ---- asynchronous reset mid-DIV ----
        writeback = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rs1 = 32'd1000; rs2 = 32'd3; md_funct3 = 3'd5;
        a_forward_select = '0; b_forward_select = '0;
        md_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        md_valid = 1'b0;
        a_forward_select = SELW'(2);
        b_forward_select = SELW'(3);
        #1;
        check("arst md_done", 32'(md_done), 32'd0);
        check("arst md_result", md_result, 32'd0);
        check("arst md_ready", 32'(md_ready), 32'd1);
        check("arst stall", 32'(stall), 32'd0);
        check("arst hist2", fwd_rs1, 32'd0);
        check("arst hist3", fwd_rs2, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("DIV after reset", 3'd4, 32'hFFFF_FF9C, 32'd7, 1'b0,
               model(3'd4, 32'hFFFF_FF9C, 32'd7), 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
